// File: rtl/psum_collector.sv
// psum_collector: gathers PE partial sums into dot products, requantizes the final sum and queues results in a FIFO.
module psum_collector #(
  parameter int SIZEIN = 16,
  parameter int SIZEOUT = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic signed [SIZEOUT-1:0]  psum_in,
  output logic                       in_ready,
  input  logic [4:0]                 shift,
  output logic signed [SIZEOUT-1:0]  fb_psum,
  output logic                       fb_clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SIZEIN-1:0]   out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sat_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [SIZEOUT:0] MAXV = {{(SIZEOUT-SIZEIN+2){1'b0}}, {(SIZEIN-1){1'b1}}};
  localparam logic signed [SIZEOUT:0] MINV = ~MAXV;
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nx;
  logic accept, launch, pop, s1_valid, clamped;
  logic signed [SIZEOUT:0] rnd, sum, sh;
  logic signed [SIZEIN-1:0] q, s1_data;
  logic signed [SIZEIN-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  // stage 1 counts against capacity so an accepted last beat always has a FIFO slot
  assign in_ready = ({1'b0, count} + (AW+2)'(s1_valid)) < (AW+2)'(DEPTH);
  assign accept = in_valid && in_ready;
  assign launch = accept && in_last;
  assign fb_clear = state == IDLE;
  assign out_valid = count != 0;
  assign pop = out_valid && out_ready;
  assign out_data = mem[rptr];
  always_comb begin
    state_nx = accept ? (in_last ? IDLE : ACC) : state;
    rnd = shift != 0 ? (SIZEOUT+1)'(1) << (shift - 5'd1) : '0;
    sum = $signed({psum_in[SIZEOUT-1], psum_in}) + rnd;
    sh = sum >>> shift;
    clamped = sh > MAXV || sh < MINV;
    q = sh > MAXV ? MAXV[SIZEIN-1:0] : sh < MINV ? MINV[SIZEIN-1:0] : sh[SIZEIN-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fb_psum <= '0;
      s1_valid <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) fb_psum <= in_last ? '0 : psum_in;
      s1_valid <= launch;
      sat_flag <= sat_flag | (launch & clamped);
      if (s1_valid) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(s1_valid) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (launch) s1_data <= q;
    if (s1_valid) mem[wptr] <= s1_data;
  end
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed self-checking bench for psum_collector.
module tb_psum_collector;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, in_ready, fb_clear, out_valid, out_ready, sat_flag;
  logic signed [39:0] psum_in, fb_psum;
  logic [4:0] shift;
  logic signed [15:0] out_data;
  logic [2:0] count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  psum_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .psum_in(psum_in),
    .in_ready(in_ready), .shift(shift), .fb_psum(fb_psum), .fb_clear(fb_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .sat_flag(sat_flag)
  );
  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(logic signed [39:0] p, logic l, logic [4:0] s);
    in_valid = 1'b1; psum_in = p; in_last = l; shift = s;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic pop_one;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  initial begin
    int acc, n, maxc;
    logic signed [15:0] exp_q [$];
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; psum_in = '0; shift = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fb_clear", fb_clear, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_fb_psum", fb_psum, 0);
    beat(1000, 1, 0);
    chk("single_fb_clear", fb_clear, 1);
    chk("single_t1_valid", out_valid, 0);
    step();
    chk("single_t2_valid", out_valid, 1);
    chk("single_data", out_data, 1000);
    chk("single_sat", sat_flag, 0);
    pop_one();
    chk("single_popped", count, 0);
    chk("three_clear0", fb_clear, 1);
    beat(5, 0, 4);
    chk("three_fb0", fb_psum, 5);
    chk("three_clear1", fb_clear, 0);
    beat(12, 0, 4);
    chk("three_fb1", fb_psum, 12);
    chk("three_clear2", fb_clear, 0);
    beat(300, 1, 4);
    chk("three_clear3", fb_clear, 1);
    chk("three_fb_last", fb_psum, 0);
    step();
    chk("three_data", out_data, 19);
    pop_one();
    beat(-24, 1, 3);
    step();
    chk("round_neg", out_data, -3);
    pop_one();
    beat(40'sd1 <<< 30, 1, 24);
    step();
    chk("max_shift", out_data, 64);
    chk("max_shift_sat", sat_flag, 0);
    pop_one();
    beat(40'sd1 <<< 30, 1, 0);
    chk("sat_flag_next", sat_flag, 1);
    step();
    chk("sat_pos", out_data, 32767);
    pop_one();
    beat(-(40'sd1 <<< 30), 1, 0);
    step();
    chk("sat_neg", out_data, -32768);
    chk("sat_sticky", sat_flag, 1);
    pop_one();
    chk("bp_empty", count, 0);
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_last = 1'b1; shift = 0; psum_in = 40'(100 + acc);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_count", count, 4);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_data", out_data, 100 + k);
      step();
    end
    out_ready = 1'b0;
    chk("bp_drained", count, 0);
    beat(7, 1, 0);
    beat(8, 1, 0);
    beat(9, 0, 0);
    chk("mid_count", count, 2);
    chk("mid_acc", fb_clear, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_count_rst", count, 0);
    chk("mid_valid_rst", out_valid, 0);
    chk("mid_clear_rst", fb_clear, 1);
    chk("mid_ready_rst", in_ready, 1);
    chk("mid_sat_rst", sat_flag, 0);
    step(); step(); step();
    chk("mid_no_stale", out_valid, 0);
    chk("mid_no_stale_cnt", count, 0);
    out_ready = 1'b1; n = 0; maxc = 0; acc = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin
        chk("wrap_data", out_data, exp_q.size() > 0 ? exp_q.pop_front() : 16'sh7abc);
        n++;
      end
      if (int'(count) > maxc) maxc = int'(count);
      if (acc < 20) begin
        in_valid = 1'b1; in_last = 1'b1; shift = 0; psum_in = 40'(acc * 37 - 200);
        if (in_ready) begin
          exp_q.push_back(16'(acc * 37 - 200));
          acc++;
        end
      end else in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("wrap_outputs", n, 20);
    chk("wrap_count_le2", maxc <= 2, 1);
    chk("wrap_empty", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
